vram_scanout: RTL and testbench

- VGA-side reader of the dual-port VRAM.
- The CPU writes 48-bit words into the VRAM, each word holding 6 × 8-bit grayscale pixels, byte 0 being the leftmost.
- This block generates 640x480@60 timing, drives the VRAM VGA read address, prefetches words and serialises their bytes into a pixel stream.
- The image is a window of IMG_W × IMG_H pixels placed at (X0, Y0); every pixel outside the window shows BG.

---
 rtl/vram_scanout.sv | 147 ++++++++++++++
 tb/tb_vram_scanout.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// 640x480@60 scan-out engine: generates VGA timing, prefetches 48-bit VRAM words
// and serialises their six grayscale bytes into the pixel stream inside the image window.
module vram_scanout #(
  parameter int          IMG_W   = 256,
  parameter int          IMG_H   = 256,
  parameter int          X0      = 192,
  parameter int          Y0      = 112,
  parameter int          PIX_DIV = 2,
  parameter logic [7:0]  BG      = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [16:0]      A_VGA,
  input  logic [5:0][7:0]  vram_i,
  output logic [7:0]       pix_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic             frame_o
);

  localparam int DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_SYNC_LO  = 10'd656;
  localparam logic [9:0] H_SYNC_HI  = 10'd751;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_SYNC_LO  = 10'd490;
  localparam logic [9:0] V_SYNC_HI  = 10'd491;

  localparam logic [10:0] WIN_H_LO = 11'(X0);
  localparam logic [10:0] WIN_H_HI = 11'(X0 + IMG_W);
  localparam logic [10:0] WIN_V_LO = 11'(Y0);
  localparam logic [10:0] WIN_V_HI = 11'(Y0 + IMG_H);

  typedef enum logic [1:0] {PRE0, PRE1, RUN} state_t;

  state_t            r_state, w_stateNext;
  logic [DIV_W-1:0]  r_div;
  logic [9:0]        r_hcnt, r_vcnt;
  logic [2:0]        r_lane;
  logic [16:0]       r_wordPtr;
  logic [5:0][7:0]   r_cur, r_nxt;
  logic              r_wait;
  logic [1:0]        r_fetch;

  logic w_tick, w_visible, w_inWin, w_frameEnd, w_preDone, w_launch;

  assign w_tick     = (r_div == DIV_MAX);
  assign w_visible  = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
  assign w_inWin    = ({1'b0, r_hcnt} >= WIN_H_LO) && ({1'b0, r_hcnt} < WIN_H_HI) &&
                      ({1'b0, r_vcnt} >= WIN_V_LO) && ({1'b0, r_vcnt} < WIN_V_HI);
  assign w_frameEnd = (r_vcnt == V_LAST) && (r_hcnt == 10'd0);
  assign w_launch   = w_tick && (r_state == RUN) && w_inWin && (r_lane == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PRE0;
    else        r_state <= w_stateNext;
  end

  // Preload walks word 0 into cur and word 1 into nxt, each waiting out the 2-clk read.
  always_comb begin
    w_stateNext = r_state;
    w_preDone   = 1'b0;
    case (r_state)
      PRE0: if (r_wait) begin
        w_preDone   = 1'b1;
        w_stateNext = PRE1;
      end
      PRE1: if (r_wait) begin
        w_preDone   = 1'b1;
        w_stateNext = RUN;
      end
      RUN: if (w_tick && w_frameEnd) w_stateNext = PRE0;
      default: w_stateNext = PRE0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_lane    <= '0;
      r_wordPtr <= '0;
      r_cur     <= '0;
      r_nxt     <= '0;
      r_wait    <= 1'b0;
      r_fetch   <= '0;
      A_VGA     <= '0;
      pix_o     <= '0;
      de_o      <= 1'b0;
      hsync_o   <= 1'b1;
      vsync_o   <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_wait  <= (r_state != RUN) ? ~r_wait : 1'b0;
      r_fetch <= {r_fetch[0], w_launch};
      frame_o <= w_tick && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

      if (r_state == PRE0 && w_preDone) begin
        r_cur <= vram_i;
        A_VGA <= 17'd1;
      end
      if (r_state == PRE1 && w_preDone) r_nxt <= vram_i;
      // Capture of the word requested two edges earlier by a lane wrap.
      if (r_fetch[1]) r_nxt <= vram_i;

      if (w_tick) begin
        de_o    <= w_visible;
        hsync_o <= !((r_hcnt >= H_SYNC_LO) && (r_hcnt <= H_SYNC_HI));
        vsync_o <= !((r_vcnt >= V_SYNC_LO) && (r_vcnt <= V_SYNC_HI));
        if (!w_visible)   pix_o <= 8'h00;
        else if (w_inWin) pix_o <= r_cur[r_lane];
        else              pix_o <= BG;

        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end

        if (r_state == RUN && w_frameEnd) begin
          r_lane    <= '0;
          r_wordPtr <= '0;
          A_VGA     <= '0;
          r_fetch   <= '0;
        end else if (r_state == RUN && w_inWin) begin
          if (r_lane == 3'd5) begin
            r_lane    <= '0;
            r_cur     <= r_nxt;
            r_wordPtr <= r_wordPtr + 17'd1;
            A_VGA     <= r_wordPtr + 17'd2;
          end else begin
            r_lane <= r_lane + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout: a small image window near the top of the frame keeps
// the run short while exercising preload, lane wrap across rows, background and mid-frame reset.
module tb_vram_scanout;

  localparam int PIX_DIV = 2;

  logic            clk;
  logic            rst_n;
  logic [16:0]     A_VGA;
  logic [5:0][7:0] vram_i;
  logic [7:0]      pix_o;
  logic            hsync_o, vsync_o, de_o, frame_o;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] val;
    string      name;
  } probe_t;

  probe_t probeQ[$];
  int     nCompared   = 0;
  int     nMismatched = 0;

  vram_scanout #(
    .IMG_W(256), .IMG_H(3), .X0(192), .Y0(2), .PIX_DIV(PIX_DIV), .BG(8'h3C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A_VGA(A_VGA), .vram_i(vram_i),
    .pix_o(pix_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .frame_o(frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: registered read behind the registered address, word n byte k = (6n+k) mod 256.
  always @(posedge clk) begin
    for (int k = 0; k < 6; k++) vram_i[k] <= 8'((6 * int'(A_VGA) + k) % 256);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushProbe(input int h, input int v, input logic [7:0] val, input string name);
    probe_t p;
    p.h = h; p.v = v; p.val = val; p.name = name;
    probeQ.push_back(p);
  endtask

  // Probes in raster order; values are pixel index mod 256 inside the window.
  task automatic applyStimulus();
    pushProbe(300, 1, 8'h3C, "bg_above");
    pushProbe(191, 2, 8'h3C, "bg_left");
    pushProbe(192, 2, 8'h00, "pix_192_2");
    pushProbe(197, 2, 8'h05, "pix_197_2");
    pushProbe(198, 2, 8'h06, "pix_198_2");
    pushProbe(700, 2, 8'h00, "blank_h700");
    pushProbe(192, 3, 8'h00, "pix_192_3");
    pushProbe(448, 3, 8'h3C, "bg_right");
    pushProbe(200, 4, 8'h08, "pix_200_4");
    pushProbe(447, 4, 8'hFF, "pix_447_4");
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"},  32'(A_VGA),   32'd0);
    checkOutput({tag, "_hsync"}, 32'(hsync_o), 32'd1);
    checkOutput({tag, "_vsync"}, 32'(vsync_o), 32'd1);
    checkOutput({tag, "_de"},    32'(de_o),    32'd0);
    checkOutput({tag, "_pix"},   32'(pix_o),   32'd0);
    checkOutput({tag, "_frame"}, 32'(frame_o), 32'd0);
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_probes_left"}, 32'(probeQ.size()), 32'd0);
    while (probeQ.size() > 0) begin
      $display("[TB] FAIL unreached probe %s at (%0d,%0d)", probeQ[0].name, probeQ[0].h, probeQ[0].v);
      void'(probeQ.pop_front());
    end
  endtask

  // Monitor: rebuilds (h,v) from frame_o/de_o edges and checks probes and sync geometry.
  int lineIdx, deClk, deHigh, hsLow;
  bit prevDe, prevHs, hsTrack;
  always @(negedge clk) begin
    if (!rst_n) begin
      lineIdx = -1; deClk = 0; deHigh = 0; hsLow = 0;
      prevDe = 1'b0; prevHs = 1'b1; hsTrack = 1'b0;
    end else begin
      if (frame_o) lineIdx = -1;
      if (de_o && !prevDe) begin
        lineIdx++; deClk = 0; deHigh = 0;
      end else begin
        deClk++;
      end
      if (lineIdx >= 0) begin
        if (de_o) deHigh++;
        if (!de_o && prevDe) checkOutput("de_width_clks", 32'(deHigh), 32'd1280);
        if (!hsync_o && prevHs) begin
          checkOutput("hsync_start_clks", 32'(deClk), 32'd1312);
          hsTrack = 1'b1; hsLow = 0;
        end
        if (!hsync_o) hsLow++;
        if (hsync_o && !prevHs && hsTrack) begin
          checkOutput("hsync_width_clks", 32'(hsLow), 32'd192);
          hsTrack = 1'b0;
        end
        if ((deClk % PIX_DIV) == 0 && probeQ.size() > 0 &&
            probeQ[0].h == deClk / PIX_DIV && probeQ[0].v == lineIdx) begin
          checkOutput(probeQ[0].name, 32'(pix_o), 32'(probeQ[0].val));
          void'(probeQ.pop_front());
        end
      end
      prevDe = de_o; prevHs = hsync_o;
    end
  end

  // Address monitor: within a frame every new address is the previous one plus one.
  logic [16:0] prevA;
  always @(negedge clk) begin
    if (!rst_n) prevA = '0;
    else begin
      if (A_VGA != prevA && A_VGA != 17'd0) checkOutput("addr_step", 32'(A_VGA), 32'(prevA) + 32'd1);
      prevA = A_VGA;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checkResetValues("reset");

    rst_n = 1'b1;
    applyStimulus();
    @(posedge clk); @(negedge clk);
    checkOutput("frame_before_tick", 32'(frame_o), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("frame_first_tick", 32'(frame_o), 32'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("frame_one_clk", 32'(frame_o), 32'd0);

    // Window ends on line 4; 128 words consumed leaves the last request at 129.
    repeat (9000) @(posedge clk);
    @(negedge clk);
    checkOutput("addr_after_window", 32'(A_VGA), 32'd129);
    checkOutput("vsync_idle", 32'(vsync_o), 32'd1);
    checkDrained("frame0");

    repeat (1200) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();

    repeat (9000) @(posedge clk);
    @(negedge clk);
    checkOutput("addr_after_restart", 32'(A_VGA), 32'd129);
    checkDrained("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
